// File: rtl/pkt_pkg.sv
// Shared definitions for the packet assembler.
// State encoding, default sync marker, small helpers.
package pkt_pkg;

    // Receive framing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHKSUM  = 2'd2
    } pkt_state_e;

    // Default start-of-packet marker.
    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

    // True while a frame is being collected and the
    // inactivity watchdog must run.
    function automatic logic in_frame(pkt_state_e s);
        return (s == ST_PAYLOAD) || (s == ST_CHKSUM);
    endfunction

endpackage

// File: rtl/echo_hold_buf.sv
// Byte echo path with a one-deep hold register.
// Arbitrates against tx_busy and flags dropped bytes.
module echo_hold_buf #(
    parameter int BYTE_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              received,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              tx_busy,
    output logic              transmit,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              echo_drop
);

    logic              hold_v_q, hold_v_d;
    logic [BYTE_W-1:0] hold_q,   hold_d;
    logic              xmit_q,   xmit_d;
    logic [BYTE_W-1:0] txb_q,    txb_d;
    logic              drop_q,   drop_d;

    // Decide what leaves this cycle and what is kept for later.
    always_comb begin
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        xmit_d   = 1'b0;
        txb_d    = txb_q;
        drop_d   = 1'b0;
        if (!tx_busy) begin
            if (hold_v_q) begin
                // Older byte goes first; a new one takes its slot.
                xmit_d   = 1'b1;
                txb_d    = hold_q;
                hold_v_d = received;
                if (received) begin
                    hold_d = rx_byte;
                end
            end else if (received) begin
                xmit_d = 1'b1;
                txb_d  = rx_byte;
            end
        end else if (received) begin
            if (!hold_v_q) begin
                hold_v_d = 1'b1;
                hold_d   = rx_byte;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Register hold state and all echo outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            xmit_q   <= 1'b0;
            txb_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            xmit_q   <= xmit_d;
            txb_q    <= txb_d;
            drop_q   <= drop_d;
        end
    end

    assign transmit  = xmit_q;
    assign tx_byte   = txb_q;
    assign echo_drop = drop_q;

endmodule

// File: rtl/packet_assembler.sv
// Frames sync/payload/checksum byte streams into packets.
// Optional echo of every received byte through echo_hold_buf.
module packet_assembler
    import pkt_pkg::*;
#(
    parameter int                BYTE_W      = 8,
    parameter int                PKT_BYTES   = 3,
    parameter logic [BYTE_W-1:0] SYNC_BYTE   = BYTE_W'(SYNC_DEFAULT),
    parameter int                TIMEOUT_CYC = 50000,
    parameter int                ECHO_EN     = 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        received,
    input  logic [BYTE_W-1:0]           rx_byte,
    input  logic                        tx_busy,
    output logic                        transmit,
    output logic [BYTE_W-1:0]           tx_byte,
    output logic [PKT_BYTES*BYTE_W-1:0] packet,
    output logic                        packet_valid,
    output logic                        chk_err,
    output logic                        timeout,
    output logic                        echo_drop
);

    localparam int PKT_W  = PKT_BYTES * BYTE_W;
    localparam int CNT_W  = $clog2(PKT_BYTES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PKT_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

    pkt_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BYTE_W-1:0] xor_q;
    logic [PKT_W-1:0]  stage_q;
    logic [IDLE_W-1:0] idle_q;
    logic [PKT_W-1:0]  packet_q;
    logic              valid_q;
    logic              err_q;
    logic              to_q;

    logic idle_hit;

    // Watchdog terminal count while a frame is open.
    assign idle_hit = in_frame(state_q) && (idle_q == IDLE_MAX);

    // Framing FSM with registered packet and status pulses.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            xor_q    <= '0;
            stage_q  <= '0;
            idle_q   <= '0;
            packet_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            if (received || !in_frame(state_q)) begin
                idle_q <= '0;
            end else if (!idle_hit) begin
                idle_q <= idle_q + IDLE_W'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (received && (rx_byte == SYNC_BYTE)) begin
                        state_q <= ST_PAYLOAD;
                        cnt_q   <= '0;
                        xor_q   <= '0;
                        stage_q <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (received) begin
                        // Sync values here are plain data.
                        stage_q <= (stage_q << BYTE_W) | PKT_W'(rx_byte);
                        xor_q   <= xor_q ^ rx_byte;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_CHKSUM;
                        end
                    end else if (idle_hit) begin
                        state_q <= ST_IDLE;
                        stage_q <= '0;
                        to_q    <= 1'b1;
                    end
                end
                ST_CHKSUM: begin
                    if (received) begin
                        if (rx_byte == xor_q) begin
                            packet_q <= stage_q;
                            valid_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else if (idle_hit) begin
                        state_q <= ST_IDLE;
                        stage_q <= '0;
                        to_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign packet       = packet_q;
    assign packet_valid = valid_q;
    assign chk_err      = err_q;
    assign timeout      = to_q;

    if (ECHO_EN != 0) begin : g_echo
        echo_hold_buf #(
            .BYTE_W (BYTE_W)
        ) u_echo (
            .Clock     (Clock),
            .Reset     (Reset),
            .received  (received),
            .rx_byte   (rx_byte),
            .tx_busy   (tx_busy),
            .transmit  (transmit),
            .tx_byte   (tx_byte),
            .echo_drop (echo_drop)
        );
    end else begin : g_no_echo
        assign transmit  = 1'b0;
        assign tx_byte   = '0;
        assign echo_drop = 1'b0;
    end

endmodule

// File: tb/tb_packet_assembler.sv
// Testbench for packet_assembler.
// Vector table, directed corner sequences and random frames.
module tb_packet_assembler;
    import pkt_pkg::*;

    localparam int PB  = 3;
    localparam int TMO = 20;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_busy = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic [23:0] packet;
    logic        packet_valid;
    logic        chk_err;
    logic        timeout;
    logic        echo_drop;

    packet_assembler #(
        .BYTE_W      (8),
        .PKT_BYTES   (PB),
        .SYNC_BYTE   (8'hAA),
        .TIMEOUT_CYC (TMO),
        .ECHO_EN     (1)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .received     (received),
        .rx_byte      (rx_byte),
        .tx_busy      (tx_busy),
        .transmit     (transmit),
        .tx_byte      (tx_byte),
        .packet       (packet),
        .packet_valid (packet_valid),
        .chk_err      (chk_err),
        .timeout      (timeout),
        .echo_drop    (echo_drop)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        v;
        logic        e;
        logic        t;
        logic        tx;
        logic [7:0]  txb;
        logic        d;
        logic [23:0] pkt;
    } out_t;

    typedef struct {
        logic       rcv;
        logic [7:0] b;
        logic       busy;
        out_t       exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit          m_open;
    logic [7:0]  m_fr[$];
    int          m_idle;
    logic [23:0] m_pkt;
    logic [7:0]  m_echo[$];

    function automatic void model_reset();
        m_open = 0;
        m_fr.delete();
        m_idle = 0;
        m_pkt  = '0;
        m_echo.delete();
    endfunction

    function automatic out_t model_step(logic rcv, logic [7:0] b,
                                        logic busy);
        out_t        e;
        logic [7:0]  x;
        logic [23:0] p;
        bit          sent;
        e    = '0;
        sent = 0;
        if (rcv) begin
            m_idle = 0;
            if (!m_open) begin
                if (b == 8'hAA) begin
                    m_open = 1;
                    m_fr.delete();
                end
            end else begin
                m_fr.push_back(b);
                if (m_fr.size() == PB + 1) begin
                    x = 0;
                    p = 0;
                    for (int i = 0; i < PB; i++) begin
                        x ^= m_fr[i];
                        p = (p << 8) | 24'(m_fr[i]);
                    end
                    if (x == m_fr[PB]) begin
                        m_pkt = p;
                        e.v   = 1;
                    end else begin
                        e.e = 1;
                    end
                    m_open = 0;
                end
            end
        end else if (m_open) begin
            m_idle++;
            if (m_idle == TMO) begin
                e.t    = 1;
                m_open = 0;
                m_idle = 0;
            end
        end
        if (!busy && m_echo.size() > 0) begin
            e.tx  = 1;
            e.txb = m_echo.pop_front();
            sent  = 1;
        end
        if (rcv) begin
            if (!busy && !sent) begin
                e.tx  = 1;
                e.txb = b;
            end else if (m_echo.size() == 0) begin
                m_echo.push_back(b);
            end else begin
                e.d = 1;
            end
        end
        e.pkt = m_pkt;
        return e;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.v   = packet_valid;
        a.e   = chk_err;
        a.t   = timeout;
        a.tx  = transmit;
        a.txb = transmit ? tx_byte : 8'h00;
        a.d   = echo_drop;
        a.pkt = packet;
        return a;
    endfunction

    function automatic void cmp(string name, out_t a, out_t w);
        checks++;
        if (a !== w) begin
            errors++;
            $display("FAIL %s: got v=%b e=%b to=%b tx=%b txb=%h drop=%b pkt=%h want v=%b e=%b to=%b tx=%b txb=%h drop=%b pkt=%h",
                     name, a.v, a.e, a.t, a.tx, a.txb, a.d, a.pkt,
                     w.v, w.e, w.t, w.tx, w.txb, w.d, w.pkt);
        end
    endfunction

    function automatic void chk(string name, logic [63:0] got,
                                logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    task automatic step(input logic rcv, input logic [7:0] b,
                        input logic busy, output out_t a);
        out_t e;
        received = rcv;
        rx_byte  = b;
        tx_busy  = busy;
        @(posedge Clock);
        #1;
        e = model_step(rcv, b, busy);
        a = sample();
        cmp("model", a, e);
    endtask

    task automatic do_reset(input int n);
        Reset    = 1'b1;
        received = 1'b0;
        rx_byte  = 8'h00;
        tx_busy  = 1'b0;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
        Reset = 1'b0;
        model_reset();
        chk("rst_outputs",
            64'({transmit, tx_byte, packet, packet_valid,
                 chk_err, timeout, echo_drop}), 64'd0);
    endtask

    function automatic vec_t mk(logic rcv, logic [7:0] b, logic busy,
                                logic v, logic e, logic tx,
                                logic [7:0] txb, logic d,
                                logic [23:0] pkt);
        vec_t r;
        r.rcv = rcv;
        r.b   = b;
        r.busy = busy;
        r.exp = '{v: v, e: e, t: 1'b0, tx: tx, txb: txb, d: d, pkt: pkt};
        return r;
    endfunction

    vec_t       tbl[$];
    logic [7:0] stream[$];
    out_t       a;

    initial begin
        // Good frame, bad frame, sync-as-data, echo hold/drop.
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 8'hAA, 0, 24'h0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 0, 1, 8'h12, 0, 24'h0));
        tbl.push_back(mk(1, 8'h34, 0, 0, 0, 1, 8'h34, 0, 24'h0));
        tbl.push_back(mk(1, 8'h56, 0, 0, 0, 1, 8'h56, 0, 24'h0));
        tbl.push_back(mk(1, 8'h70, 0, 1, 0, 1, 8'h70, 0, 24'h123456));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 8'hAA, 0, 24'h123456));
        tbl.push_back(mk(1, 8'h12, 0, 0, 0, 1, 8'h12, 0, 24'h123456));
        tbl.push_back(mk(1, 8'h34, 0, 0, 0, 1, 8'h34, 0, 24'h123456));
        tbl.push_back(mk(1, 8'h56, 0, 0, 0, 1, 8'h56, 0, 24'h123456));
        tbl.push_back(mk(1, 8'h71, 0, 0, 1, 1, 8'h71, 0, 24'h123456));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 8'hAA, 0, 24'h123456));
        tbl.push_back(mk(1, 8'hAA, 0, 0, 0, 1, 8'hAA, 0, 24'h123456));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 8'h01, 0, 24'h123456));
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 1, 8'h02, 0, 24'h123456));
        tbl.push_back(mk(1, 8'hA9, 0, 1, 0, 1, 8'hA9, 0, 24'hAA0102));
        tbl.push_back(mk(1, 8'h11, 1, 0, 0, 0, 8'h00, 0, 24'hAA0102));
        tbl.push_back(mk(1, 8'h22, 1, 0, 0, 0, 8'h00, 1, 24'hAA0102));
        tbl.push_back(mk(1, 8'h33, 1, 0, 0, 0, 8'h00, 1, 24'hAA0102));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h11, 0, 24'hAA0102));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 24'hAA0102));
        tbl.push_back(mk(1, 8'h44, 1, 0, 0, 0, 8'h00, 0, 24'hAA0102));
        tbl.push_back(mk(1, 8'h55, 0, 0, 0, 1, 8'h44, 0, 24'hAA0102));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h55, 0, 24'hAA0102));

        model_reset();
        do_reset(3);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));

        foreach (tbl[i]) begin
            step(tbl[i].rcv, tbl[i].b, tbl[i].busy, a);
            cmp($sformatf("tbl[%0d]", i), a, tbl[i].exp);
        end

        // Timeout after 20 idle cycles, then a fresh frame.
        step(1, 8'hAA, 0, a);
        step(1, 8'h12, 0, a);
        for (int i = 0; i < TMO - 1; i++) begin
            step(0, 8'h00, 0, a);
        end
        step(0, 8'h00, 0, a);
        chk("to_pulse", 64'(a.t), 64'd1);
        step(0, 8'h00, 0, a);
        chk("to_single", 64'(a.t), 64'd0);
        step(1, 8'hAA, 0, a);
        step(1, 8'h01, 0, a);
        step(1, 8'h02, 0, a);
        step(1, 8'h03, 0, a);
        step(1, 8'h00, 0, a);
        chk("to_next_valid", 64'(a.v), 64'd1);
        chk("to_next_pkt", 64'(a.pkt), 64'h010203);

        // Byte arriving on the terminal idle cycle wins.
        step(1, 8'hAA, 0, a);
        step(1, 8'h12, 0, a);
        for (int i = 0; i < TMO - 1; i++) begin
            step(0, 8'h00, 0, a);
        end
        step(1, 8'h34, 0, a);
        chk("tc_no_timeout", 64'(a.t), 64'd0);
        step(1, 8'h56, 0, a);
        step(1, 8'h70, 0, a);
        chk("tc_valid", 64'(a.v), 64'd1);
        chk("tc_pkt", 64'(a.pkt), 64'h123456);

        // Reset in the middle of a frame discards it silently.
        step(1, 8'hAA, 0, a);
        step(1, 8'h12, 0, a);
        do_reset(1);
        step(1, 8'h34, 0, a);
        step(1, 8'h56, 0, a);
        step(1, 8'h70, 0, a);
        chk("mid_rst_flags", 64'({a.v, a.e, a.t}), 64'd0);
        chk("mid_rst_pkt", 64'(a.pkt), 64'd0);

        // Random frames with busy stalls and long gaps.
        for (int f = 0; f < 120; f++) begin
            logic [7:0] x;
            logic [7:0] d;
            if ($urandom_range(0, 4) == 0) begin
                stream.push_back(8'($urandom));
            end
            stream.push_back(8'hAA);
            x = 0;
            for (int k = 0; k < PB; k++) begin
                d = ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom);
                stream.push_back(d);
                x ^= d;
            end
            if ($urandom_range(0, 3) == 0) begin
                x ^= 8'h5A;
            end
            stream.push_back(x);
        end
        while (stream.size() > 0) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                repeat (TMO + 1) begin
                    step(0, 8'h00, 1'($urandom_range(0, 1)), a);
                end
            end else if (r < 70) begin
                step(1, stream.pop_front(),
                     1'($urandom_range(0, 3) == 0), a);
            end else begin
                step(0, 8'h00, 1'($urandom_range(0, 2) == 0), a);
            end
        end
        repeat (4) step(0, 8'h00, 0, a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
